morph_program_engine: RTL
=========================

Name: morph_program_engine

Overview:
- Programmable successor to the single-step morphological processor: holds a small instruction memory and executes a sequence of morphology + combine steps on one latched binary image.
- Each step runs in one clock, with start/busy/done handshaking and abort.
- Generalised in image size and program depth.
- Reuses the existing MorphologicUnit for the morphology datapath; the combine stage is local to this block.

Parameters:
ImageWidth, 8, image columns
ImageHeight, 8, image rows
ProgDepth, 8, instruction memory entries
ProgAddrWidth, 3, clog2(ProgDepth); address and pc width

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
progWe  in  1  instruction write strobe
progAddr  in  ProgAddrWidth  instruction write address
progData  in  16  instruction word
progLen  in  ProgAddrWidth+1  steps to run, sampled with start
start  in  1  begin run (honoured in IDLE only)
abort  in  1  terminate run
image  in  ImageWidth*ImageHeight  source image, sampled with start
busy  out  1  high while RUN
done  out  1  one-cycle pulse on normal completion
pc  out  ProgAddrWidth  index of the instruction executing this cycle
imageAcc  out  ImageWidth*ImageHeight  accumulator / result

Behaviour:
- Instruction word fields:
  - [15:7] el: structuring element for MorphologicUnit.
  - [6:4] morphOp: MorphologicUnit op.
  - [3] srcSel: 1 = latched image, 0 = imageAcc.
  - [2:1] comb: 00 acc<=M, 01 acc<=acc&M, 10 acc<=acc|M, 11 acc<=acc^M, where M is the MorphologicUnit result.
  - [0] reserved; write 0, ignore on read.
- Instruction memory: flop array, combinational read, written on the clk edge when progWe=1 and state is IDLE or DONE. Writes are ignored while busy.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 latches image into imgReg, sets imageAcc<=image and pc<=0.
  - Next state is RUN if effective length L is nonzero, else DONE.
  - L = min(progLen, ProgDepth).
- RUN:
  - Each edge executes mem[pc] and updates imageAcc.
  - If pc==L-1, next state is DONE; otherwise pc<=pc+1.
  - busy=1 throughout RUN.
- DONE: done=1 for exactly this one cycle, then IDLE. pc holds its final value.
- Latency: start sampled at edge E0; steps execute at E1..EL; done is high in the cycle after EL. With L=0, done is high in the cycle after E0.
- abort=1 in RUN: next state IDLE, imageAcc keeps the result of steps already completed, no done pulse. The step on that edge is not executed.
- abort=1 in IDLE or DONE: no effect.
- abort has priority over completion on the same edge.
- start while RUN or DONE: ignored.
- progWe and start on the same edge in IDLE: the write lands first; it is visible to step 1 at E1.
- image changes during RUN: no effect, because srcSel=1 uses imgReg.
- Reset (any time, including mid-run): state=IDLE, busy=0, done=0, pc=0, imageAcc=0, imgReg=0, all instruction words=0.
- All image widths are ImageWidth*ImageHeight bits. The combine is bitwise, with no carries.

Test Plan:
- Constants:
  - X = 64'hAA55AA55AA55AA55.
  - Ec = 9'b000010000 (center-only element; erosion and dilation are identity).
  - Ix = {Ec, 3'd0, 1'b1, 2'b11, 1'b0} (XOR with latched image).
- L=1 pass-through: mem[0]={Ec,3'd0,1,2'b00,0}, image=X, start -> busy for 1 cycle; done pulse 2 cycles after the start edge; imageAcc=X.
- XOR chain: mem[0..2]=Ix, L=3, image=X -> imageAcc after E1/E2/E3 = 0/X/0; done once; pc sequence 0,1,2.
- Abort: L=8 all Ix, abort asserted at E3 -> state IDLE, imageAcc=X (2 steps done), done never pulses.
- L=0 and progLen=15 with ProgDepth=8 -> done the cycle after E0 with imageAcc=X; clamped run executes exactly 8 steps.
- start and progWe during RUN -> ignored: memory unchanged, run completes normally. A second start in the DONE cycle is ignored; a start issued one cycle later is accepted.
- rst asserted mid-RUN between edges -> busy, done, pc and imageAcc are 0 immediately; memory is cleared, so a following L=1 run yields imageAcc=0 (all-zero el).

Source files
------------

// File: rtl/morph_program_engine.sv
// Programmable morphology engine: a small instruction memory drives a sequence
// of single-cycle morphology + combine steps on one latched binary image.
// The morphology datapath lives in MorphologicUnit, defined at the end of this file.

module morph_program_engine #(
  parameter int ImageWidth    = 8,
  parameter int ImageHeight   = 8,
  parameter int ProgDepth     = 8,
  parameter int ProgAddrWidth = 3
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               progWe,
  input  logic [ProgAddrWidth-1:0]           progAddr,
  input  logic [15:0]                        progData,
  input  logic [ProgAddrWidth:0]             progLen,
  input  logic                               start,
  input  logic                               abort,
  input  logic [ImageWidth*ImageHeight-1:0]  image,
  output logic                               busy,
  output logic                               done,
  output logic [ProgAddrWidth-1:0]           pc,
  output logic [ImageWidth*ImageHeight-1:0]  imageAcc
);

  localparam int N = ImageWidth * ImageHeight;
  localparam logic [ProgAddrWidth:0] DEPTH_L = (ProgAddrWidth+1)'(ProgDepth);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                   state_reg, state_next;
  logic [ProgAddrWidth-1:0] pc_reg, pc_next;
  logic [ProgAddrWidth:0]   len_reg, len_next;
  logic [N-1:0]             acc_reg, acc_next;
  logic [N-1:0]             img_reg, img_next;

  logic [15:0]              mem [ProgDepth];
  logic [15:0]              instr;
  logic [N-1:0]             morph_src;
  logic [N-1:0]             morph_res;
  logic [N-1:0]             comb_res;
  logic [ProgAddrWidth:0]   len_eff;
  logic                     unused_rsvd;

  // Instruction memory: one flop word per entry, frozen while a run is active.
  generate
    for (genvar gi = 0; gi < ProgDepth; gi++) begin : g_mem
      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          mem[gi] <= '0;
        else if (progWe && (state_reg != RUN) && (progAddr == ProgAddrWidth'(gi)))
          mem[gi] <= progData;
      end
    end
  endgenerate

  assign instr       = mem[pc_reg];
  assign unused_rsvd = instr[0];
  assign morph_src   = instr[3] ? img_reg : acc_reg;
  assign len_eff     = (progLen > DEPTH_L) ? DEPTH_L : progLen;

  MorphologicUnit #(
    .ImageWidth (ImageWidth),
    .ImageHeight(ImageHeight)
  ) u_morph (
    .src(morph_src),
    .el (instr[15:7]),
    .op (instr[6:4]),
    .res(morph_res)
  );

  // Bitwise combine of the morphology result into the accumulator.
  always_comb begin
    comb_res = morph_res;
    case (instr[2:1])
      2'b00:   comb_res = morph_res;
      2'b01:   comb_res = acc_reg & morph_res;
      2'b10:   comb_res = acc_reg | morph_res;
      default: comb_res = acc_reg ^ morph_res;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      pc_reg    <= '0;
      len_reg   <= '0;
      acc_reg   <= '0;
      img_reg   <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      len_reg   <= len_next;
      acc_reg   <= acc_next;
      img_reg   <= img_next;
    end
  end

  // Next-state and datapath decisions; abort wins over completion in RUN.
  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    len_next   = len_reg;
    acc_next   = acc_reg;
    img_next   = img_reg;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          img_next   = image;
          acc_next   = image;
          pc_next    = '0;
          len_next   = len_eff;
          state_next = (len_eff != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (abort) begin
          state_next = IDLE;
        end else begin
          acc_next = comb_res;
          if ({1'b0, pc_reg} == (len_reg - 1'b1))
            state_next = DONE;
          else
            pc_next = pc_reg + 1'b1;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign pc       = pc_reg;
  assign imageAcc = acc_reg;

endmodule

// 3x3 binary morphology on a row-major image (pixel r,c at bit r*W+c).
// el bit (dr+1)*3+(dc+1) selects neighbour offset (dr,dc); pixels outside
// the image read as 0. op: 0 dilate, 1 erode, 2 pass, 3 invert,
// 4 inner boundary (src & ~erode), 5 outer boundary (dilate & ~src), else pass.
module MorphologicUnit #(
  parameter int ImageWidth  = 8,
  parameter int ImageHeight = 8
) (
  input  logic [ImageWidth*ImageHeight-1:0] src,
  input  logic [8:0]                        el,
  input  logic [2:0]                        op,
  output logic [ImageWidth*ImageHeight-1:0] res
);

  generate
    for (genvar gi = 0; gi < ImageHeight; gi++) begin : g_row
      for (genvar gj = 0; gj < ImageWidth; gj++) begin : g_col
        logic [8:0] nb;
        logic       dil;
        logic       ero;
        logic       ctr;
        for (genvar gk = 0; gk < 9; gk++) begin : g_nb
          localparam int RR = gi + (gk / 3) - 1;
          localparam int CC = gj + (gk % 3) - 1;
          if (RR >= 0 && RR < ImageHeight && CC >= 0 && CC < ImageWidth) begin : g_in
            assign nb[gk] = src[RR*ImageWidth + CC];
          end else begin : g_out
            assign nb[gk] = 1'b0;
          end
        end
        assign dil = |(nb & el);
        assign ero = &(nb | ~el);
        assign ctr = src[gi*ImageWidth + gj];
        // Per-pixel operator select.
        always_comb begin
          res[gi*ImageWidth + gj] = ctr;
          case (op)
            3'd0:    res[gi*ImageWidth + gj] = dil;
            3'd1:    res[gi*ImageWidth + gj] = ero;
            3'd2:    res[gi*ImageWidth + gj] = ctr;
            3'd3:    res[gi*ImageWidth + gj] = ~ctr;
            3'd4:    res[gi*ImageWidth + gj] = ctr & ~ero;
            3'd5:    res[gi*ImageWidth + gj] = dil & ~ctr;
            default: res[gi*ImageWidth + gj] = ctr;
          endcase
        end
      end
    end
  endgenerate

endmodule
